// File: rtl/ls_exec_unit_pkg.sv
// Shared types and constants for the load/store execution stage.
// Opcodes keep loads below stores so a single compare separates them.
package ls_exec_unit_pkg;

  localparam int unsigned OPENUM_W = 3;
  localparam int unsigned ROB_ID_W = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 32;

  localparam logic [ROB_ID_W-1:0] ZERO_ROB  = '0;
  localparam logic [DATA_W-1:0]   ZERO_WORD = '0;
  localparam logic                TRUE      = 1'b1;
  localparam logic                FALSE     = 1'b0;

  typedef enum logic [OPENUM_W-1:0] {
    OpLb  = 3'd0,
    OpLh  = 3'd1,
    OpLw  = 3'd2,
    OpLbu = 3'd3,
    OpLhu = 3'd4,
    OpSb  = 3'd5,
    OpSh  = 3'd6,
    OpSw  = 3'd7
  } openum_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StReq  = 1'b1
  } state_e;

  function automatic logic is_load(openum_e op);
    return op <= OpLhu;
  endfunction

  // Byte count presented to the memory controller.
  function automatic logic [2:0] op_size(openum_e op);
    logic [2:0] size;
    case (op)
      OpLb, OpLbu, OpSb: size = 3'd1;
      OpLh, OpLhu, OpSh: size = 3'd2;
      default:           size = 3'd4;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/ls_exec_unit_if.sv
// Issue, memory-controller and LS CDB signals of the load/store execution stage.
// master is the execution unit's view; slave is the surrounding buffer/memory/ROB.
interface ls_exec_unit_if;
  import ls_exec_unit_pkg::*;

  logic                rdy;
  logic                ena_in;
  logic [OPENUM_W-1:0] openum_in;
  logic [ADDR_W-1:0]   addr_in;
  logic [DATA_W-1:0]   store_value_in;
  logic [ROB_ID_W-1:0] rob_id_in;
  logic                busy_out;
  logic                mem_ena_out;
  logic                mem_wr_out;
  logic [ADDR_W-1:0]   mem_addr_out;
  logic [2:0]          mem_size_out;
  logic [DATA_W-1:0]   mem_wdata_out;
  logic                mem_done_in;
  logic [DATA_W-1:0]   mem_rdata_in;
  logic                cdb_valid_out;
  logic [ROB_ID_W-1:0] cdb_rob_id_out;
  logic [DATA_W-1:0]   cdb_result_out;
  logic                flush_in;

  modport master (
    input  rdy, ena_in, openum_in, addr_in, store_value_in, rob_id_in,
    input  mem_done_in, mem_rdata_in, flush_in,
    output busy_out, mem_ena_out, mem_wr_out, mem_addr_out, mem_size_out, mem_wdata_out,
    output cdb_valid_out, cdb_rob_id_out, cdb_result_out
  );

  modport slave (
    output rdy, ena_in, openum_in, addr_in, store_value_in, rob_id_in,
    output mem_done_in, mem_rdata_in, flush_in,
    input  busy_out, mem_ena_out, mem_wr_out, mem_addr_out, mem_size_out, mem_wdata_out,
    input  cdb_valid_out, cdb_rob_id_out, cdb_result_out
  );

endinterface

// File: rtl/ls_load_extender.sv
// Combinational sign/zero extension of raw load data by opcode.
// Kept standalone so store-to-load forwarding can reuse it.
module ls_load_extender
  import ls_exec_unit_pkg::*;
(
  input  openum_e           i_op,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [DATA_W-1:0] o_result
);

  always_comb begin
    o_result = i_rdata;
    case (i_op)
      OpLb:    o_result = {{(DATA_W - 8){i_rdata[7]}}, i_rdata[7:0]};
      OpLbu:   o_result = {{(DATA_W - 8){1'b0}}, i_rdata[7:0]};
      OpLh:    o_result = {{(DATA_W - 16){i_rdata[15]}}, i_rdata[15:0]};
      OpLhu:   o_result = {{(DATA_W - 16){1'b0}}, i_rdata[15:0]};
      default: o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/ls_exec_unit.sv
// Load/store execution stage: one outstanding memory request, load results on the LS CDB.
// Flushed loads still wait for the controller but their broadcast is dropped.
module ls_exec_unit
  import ls_exec_unit_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  ls_exec_unit_if.master bus
);

  state_e              r_state,        w_state_next;
  openum_e             r_op,           w_op_next;
  logic                r_discard,      w_discard_next;
  logic [ROB_ID_W-1:0] r_rob_id,       w_rob_id_next;
  logic                r_mem_ena,      w_mem_ena_next;
  logic                r_mem_wr,       w_mem_wr_next;
  logic [ADDR_W-1:0]   r_mem_addr,     w_mem_addr_next;
  logic [2:0]          r_mem_size,     w_mem_size_next;
  logic [DATA_W-1:0]   r_mem_wdata,    w_mem_wdata_next;
  logic                r_cdb_valid,    w_cdb_valid_next;
  logic [ROB_ID_W-1:0] r_cdb_rob_id,   w_cdb_rob_id_next;
  logic [DATA_W-1:0]   r_cdb_result,   w_cdb_result_next;

  openum_e             w_op_in;
  logic [DATA_W-1:0]   w_ext_result;

  assign w_op_in = openum_e'(bus.openum_in);

  ls_load_extender u_load_extender (
    .i_op     (r_op),
    .i_rdata  (bus.mem_rdata_in),
    .o_result (w_ext_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_op         <= OpLb;
      r_discard    <= FALSE;
      r_rob_id     <= ZERO_ROB;
      r_mem_ena    <= FALSE;
      r_mem_wr     <= FALSE;
      r_mem_addr   <= '0;
      r_mem_size   <= 3'd0;
      r_mem_wdata  <= ZERO_WORD;
      r_cdb_valid  <= FALSE;
      r_cdb_rob_id <= ZERO_ROB;
      r_cdb_result <= ZERO_WORD;
    end else begin
      r_state      <= w_state_next;
      r_op         <= w_op_next;
      r_discard    <= w_discard_next;
      r_rob_id     <= w_rob_id_next;
      r_mem_ena    <= w_mem_ena_next;
      r_mem_wr     <= w_mem_wr_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_size   <= w_mem_size_next;
      r_mem_wdata  <= w_mem_wdata_next;
      r_cdb_valid  <= w_cdb_valid_next;
      r_cdb_rob_id <= w_cdb_rob_id_next;
      r_cdb_result <= w_cdb_result_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_op_next         = r_op;
    w_discard_next    = r_discard;
    w_rob_id_next     = r_rob_id;
    w_mem_ena_next    = r_mem_ena;
    w_mem_wr_next     = r_mem_wr;
    w_mem_addr_next   = r_mem_addr;
    w_mem_size_next   = r_mem_size;
    w_mem_wdata_next  = r_mem_wdata;
    w_cdb_valid_next  = r_cdb_valid;
    w_cdb_rob_id_next = r_cdb_rob_id;
    w_cdb_result_next = r_cdb_result;

    // With rdy low everything holds, including a pending CDB pulse.
    if (bus.rdy) begin
      w_cdb_valid_next = FALSE;
      case (r_state)
        StIdle: begin
          // A load issued under flush belongs to the squashed path.
          if (bus.ena_in && !(bus.flush_in && is_load(w_op_in))) begin
            w_state_next     = StReq;
            w_op_next        = w_op_in;
            w_rob_id_next    = bus.rob_id_in;
            w_mem_ena_next   = TRUE;
            w_mem_wr_next    = !is_load(w_op_in);
            w_mem_addr_next  = bus.addr_in;
            w_mem_size_next  = op_size(w_op_in);
            w_mem_wdata_next = bus.store_value_in;
          end
        end
        StReq: begin
          if (bus.flush_in && is_load(r_op)) begin
            w_discard_next = TRUE;
          end
          if (bus.mem_done_in) begin
            w_state_next   = StIdle;
            w_mem_ena_next = FALSE;
            w_discard_next = FALSE;
            // A flush coinciding with completion also kills the broadcast.
            if (is_load(r_op) && !r_discard && !bus.flush_in) begin
              w_cdb_valid_next  = TRUE;
              w_cdb_rob_id_next = r_rob_id;
              w_cdb_result_next = w_ext_result;
            end
          end
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  assign bus.busy_out       = (r_state != StIdle) || bus.ena_in;
  assign bus.mem_ena_out    = r_mem_ena;
  assign bus.mem_wr_out     = r_mem_wr;
  assign bus.mem_addr_out   = r_mem_addr;
  assign bus.mem_size_out   = r_mem_size;
  assign bus.mem_wdata_out  = r_mem_wdata;
  assign bus.cdb_valid_out  = r_cdb_valid;
  assign bus.cdb_rob_id_out = r_cdb_rob_id;
  assign bus.cdb_result_out = r_cdb_result;

endmodule

// File: tb/tb_ls_exec_unit.sv
// Bench for ls_exec_unit: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ls_exec_unit;
  import ls_exec_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;

  ls_exec_unit_if bus();

  ls_exec_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_cdb    = 0;
  bit model_live = 1'b0;

  // Reference model: one outstanding request plus the last broadcast.
  bit          m_pend = 1'b0;
  bit          m_disc = 1'b0;
  bit          m_cdb_v = 1'b0;
  logic [2:0]  m_op;
  logic [31:0] m_addr, m_wdata, m_cdb_res;
  logic [3:0]  m_tag, m_cdb_tag;

  function automatic bit ld(logic [2:0] op);
    return op inside {OpLb, OpLh, OpLw, OpLbu, OpLhu};
  endfunction

  function automatic logic [31:0] nbytes(logic [2:0] op);
    if (op inside {OpLb, OpLbu, OpSb}) return 32'd1;
    if (op inside {OpLh, OpLhu, OpSh}) return 32'd2;
    return 32'd4;
  endfunction

  function automatic logic [31:0] extend(logic [2:0] op, logic [31:0] raw);
    longint v;
    v = longint'(raw);
    case (op)
      OpLb:  begin v = v % 256;   if (v > 127)   v = v - 256;   end
      OpLbu: v = v % 256;
      OpLh:  begin v = v % 65536; if (v > 32767) v = v - 65536; end
      OpLhu: v = v % 65536;
      default: ;
    endcase
    return v[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_pend = 0; m_disc = 0; m_cdb_v = 0;
    end else if (bus.rdy) begin
      if (m_pend) begin
        if (bus.flush_in && ld(m_op)) m_disc = 1;
        if (bus.mem_done_in) begin
          m_pend    = 0;
          m_cdb_v   = ld(m_op) && !m_disc;
          m_cdb_tag = m_tag;
          m_cdb_res = extend(m_op, bus.mem_rdata_in);
          m_disc    = 0;
        end else begin
          m_cdb_v = 0;
        end
      end else begin
        m_cdb_v = 0;
        if (bus.ena_in && !(bus.flush_in && ld(bus.openum_in))) begin
          m_pend  = 1;
          m_op    = bus.openum_in;
          m_addr  = bus.addr_in;
          m_wdata = bus.store_value_in;
          m_tag   = bus.rob_id_in;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    model_live = 1'b1;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_live) begin
      chk("busy", 32'(bus.busy_out), 32'(m_pend || bus.ena_in));
      chk("mem_ena", 32'(bus.mem_ena_out), 32'(m_pend));
      if (m_pend) begin
        chk("mem_wr", 32'(bus.mem_wr_out), 32'(!ld(m_op)));
        chk("mem_addr", bus.mem_addr_out, m_addr);
        chk("mem_size", 32'(bus.mem_size_out), nbytes(m_op));
        chk("mem_wdata", bus.mem_wdata_out, m_wdata);
      end
      chk("cdb_valid", 32'(bus.cdb_valid_out), 32'(m_cdb_v));
      if (m_cdb_v) begin
        chk("cdb_rob_id", 32'(bus.cdb_rob_id_out), 32'(m_cdb_tag));
        chk("cdb_result", bus.cdb_result_out, m_cdb_res);
      end
      if (bus.cdb_valid_out === 1'b1) n_cdb++;
    end
  end

  task automatic idle_inputs();
    bus.rdy = 1; bus.ena_in = 0; bus.openum_in = OpLb; bus.addr_in = '0;
    bus.store_value_in = '0; bus.rob_id_in = '0; bus.mem_done_in = 0;
    bus.mem_rdata_in = '0; bus.flush_in = 0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] val,
                       input logic [3:0] tag);
    bus.ena_in = 1; bus.openum_in = op; bus.addr_in = addr;
    bus.store_value_in = val; bus.rob_id_in = tag;
    tick();
    bus.ena_in = 0;
  endtask

  task automatic done(input logic [31:0] rdata);
    bus.mem_done_in = 1; bus.mem_rdata_in = rdata;
    tick();
    bus.mem_done_in = 0;
  endtask

  task automatic load_check(input string name, input logic [2:0] op, input logic [31:0] rdata,
                            input logic [31:0] exp);
    issue(op, 32'h0000_0100, 32'h0, 4'd1);
    tick();
    done(rdata);
    chk({name, "_valid"}, 32'(bus.cdb_valid_out), 32'd1);
    chk(name, bus.cdb_result_out, exp);
    tick();
  endtask

  int c0;

  initial begin
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;

    chk("rst_mem_ena", 32'(bus.mem_ena_out), 32'd0);
    chk("rst_mem_wr", 32'(bus.mem_wr_out), 32'd0);
    chk("rst_mem_addr", bus.mem_addr_out, 32'd0);
    chk("rst_mem_size", 32'(bus.mem_size_out), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata_out, 32'd0);
    chk("rst_cdb_valid", 32'(bus.cdb_valid_out), 32'd0);
    chk("rst_cdb_rob_id", 32'(bus.cdb_rob_id_out), 32'd0);
    chk("rst_cdb_result", bus.cdb_result_out, 32'd0);
    chk("rst_busy", 32'(bus.busy_out), 32'd0);

    // LW with three-cycle memory latency.
    c0 = n_cdb;
    issue(OpLw, 32'h0000_1000, 32'h0, 4'd3);
    chk("lw_size", 32'(bus.mem_size_out), 32'd4);
    chk("lw_busy", 32'(bus.busy_out), 32'd1);
    tick();
    tick();
    done(32'hDEAD_BEEF);
    chk("lw_cdb_valid", 32'(bus.cdb_valid_out), 32'd1);
    chk("lw_cdb_tag", 32'(bus.cdb_rob_id_out), 32'd3);
    chk("lw_cdb_result", bus.cdb_result_out, 32'hDEAD_BEEF);
    tick();
    chk("lw_cdb_drop", 32'(bus.cdb_valid_out), 32'd0);
    chk("lw_pulses", 32'(n_cdb - c0), 32'd1);

    load_check("ext_lb", OpLb, 32'h0000_0080, 32'hFFFF_FF80);
    load_check("ext_lbu", OpLbu, 32'h0000_0080, 32'h0000_0080);
    load_check("ext_lh", OpLh, 32'h0000_F00F, 32'hFFFF_F00F);
    load_check("ext_lhu", OpLhu, 32'h0000_F00F, 32'h0000_F00F);
    load_check("ext_lb_pos", OpLb, 32'hABCD_127F, 32'h0000_007F);

    // SH: request held until done, no broadcast.
    c0 = n_cdb;
    issue(OpSh, 32'h0000_0020, 32'h1234_5678, 4'd5);
    chk("sh_wr", 32'(bus.mem_wr_out), 32'd1);
    chk("sh_size", 32'(bus.mem_size_out), 32'd2);
    tick();
    tick();
    chk("sh_wdata_held", bus.mem_wdata_out, 32'h1234_5678);
    done(32'h0);
    chk("sh_no_cdb", 32'(bus.cdb_valid_out), 32'd0);
    tick();
    chk("sh_pulses", 32'(n_cdb - c0), 32'd0);

    // Flush of an outstanding LW.
    c0 = n_cdb;
    issue(OpLw, 32'h0000_0040, 32'h0, 4'd7);
    tick();
    bus.flush_in = 1;
    tick();
    bus.flush_in = 0;
    tick();
    chk("flush_still_req", 32'(bus.mem_ena_out), 32'd1);
    done(32'h0000_0055);
    chk("flush_busy_drop", 32'(bus.busy_out), 32'd0);
    chk("flush_no_cdb", 32'(bus.cdb_valid_out), 32'd0);
    tick();
    chk("flush_pulses", 32'(n_cdb - c0), 32'd0);
    load_check("post_flush_lw", OpLw, 32'h0000_1234, 32'h0000_1234);

    // Flush coinciding with issue: load dropped, store accepted.
    bus.flush_in = 1;
    issue(OpLb, 32'h0000_0060, 32'h0, 4'd2);
    chk("flush_ld_drop", 32'(bus.mem_ena_out), 32'd0);
    issue(OpSw, 32'h0000_0080, 32'hCAFE_F00D, 4'd4);
    bus.flush_in = 0;
    chk("flush_st_keep", 32'(bus.mem_ena_out), 32'd1);
    chk("flush_st_wr", 32'(bus.mem_wr_out), 32'd1);
    done(32'h0);
    tick();

    // Stall mid-request with done toggling.
    c0 = n_cdb;
    issue(OpLhu, 32'h0000_0300, 32'h0, 4'd2);
    tick();
    bus.rdy = 0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_done_in = (i % 2 == 0);
      bus.mem_rdata_in = $urandom;
      tick();
      chk("stall_mem_ena", 32'(bus.mem_ena_out), 32'd1);
      chk("stall_no_cdb", 32'(bus.cdb_valid_out), 32'd0);
    end
    bus.rdy = 1;
    bus.mem_done_in = 0;
    tick();
    done(32'h0000_8001);
    chk("stall_cdb", bus.cdb_result_out, 32'h0000_8001);
    tick();
    tick();
    chk("stall_pulses", 32'(n_cdb - c0), 32'd1);

    // Back-to-back issue right after completion.
    issue(OpLw, 32'h0000_0100, 32'h0, 4'd10);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b2b_busy", 32'(bus.busy_out), 32'd1);
    end
    done(32'h1);
    issue(OpLbu, 32'h0000_0204, 32'h0, 4'd11);
    chk("b2b_addr", bus.mem_addr_out, 32'h0000_0204);
    chk("b2b_ena", 32'(bus.mem_ena_out), 32'd1);
    done(32'h0000_01FF);
    chk("b2b_tag", 32'(bus.cdb_rob_id_out), 32'd11);
    chk("b2b_result", bus.cdb_result_out, 32'h0000_00FF);
    tick();

    // Randomized traffic, including stalls, flushes, spurious dones and resets.
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.rdy = ($urandom_range(0, 7) != 0);
      bus.flush_in = ($urandom_range(0, 11) == 0);
      bus.mem_done_in = m_pend ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      bus.mem_rdata_in = $urandom;
      if (!m_pend && $urandom_range(0, 2) == 0) begin
        bus.ena_in = 1;
        bus.openum_in = 3'($urandom_range(0, 7));
        bus.addr_in = $urandom;
        bus.store_value_in = $urandom;
        bus.rob_id_in = 4'($urandom_range(0, 15));
      end else begin
        bus.ena_in = 0;
      end
      tick();
    end
    rst = 0;
    idle_inputs();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ls_exec_unit.md
Name: ls_exec_unit

Overview:
- Load/store execution stage directly downstream of the load/store buffer.
- Accepts one memory operation at a time (opcode, effective address, store value, ROB id) and drives the memory controller through a request/done handshake.
- Extends load data and broadcasts load results on the LS CDB; stores complete silently.
- Exposes a combinational busy so the buffer never issues into an occupied unit.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- ROB_ID_W, 4, ROB tag width; tag 0 means "no tag"

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low freezes all state
- ena_in  in  1  one-cycle issue strobe from LS buffer
- openum_in  in  OPENUM_W  opcode (LB/LH/LW/LBU/LHU/SB/SH/SW)
- addr_in  in  ADDR_W  effective address
- store_value_in  in  DATA_W  store data
- rob_id_in  in  ROB_ID_W  ROB tag of the operation
- busy_out  out  1  unit occupied (combinational)
- mem_ena_out  out  1  memory request valid
- mem_wr_out  out  1  1=store, 0=load
- mem_addr_out  out  ADDR_W  request address
- mem_size_out  out  3  byte count: 1, 2 or 4
- mem_wdata_out  out  DATA_W  store data, low bytes significant
- mem_done_in  in  1  one-cycle completion pulse
- mem_rdata_in  in  DATA_W  load data, valid with mem_done_in
- cdb_valid_out  out  1  LS CDB broadcast valid
- cdb_rob_id_out  out  ROB_ID_W  broadcast tag
- cdb_result_out  out  DATA_W  extended load result
- flush_in  in  1  commit-time jump / mispredict flush from ROB

Behaviour:
- Reset values:
  - state = IDLE.
  - mem_ena_out, mem_wr_out, cdb_valid_out = 0.
  - mem_addr_out, mem_wdata_out, cdb_result_out = 0.
  - mem_size_out = 0; cdb_rob_id_out = 0.
  - discard flag = 0.
- States: IDLE, REQ (request outstanding).
- busy_out = (state != IDLE) || ena_in. It covers the issue cycle, so a back-to-back issue is impossible.
- rdy low: every register holds its value, and mem_done_in is ignored (the controller is stalled too).
- IDLE, ena_in=1 at edge N: latch opcode, addr, data and tag. The request appears at N+1:
  - mem_ena_out=1, fields driven.
  - mem_size_out from the opcode.
  - mem_wr_out = opcode>=SB.
  - state -> REQ.
- REQ: mem_ena_out and all request fields are held stable until mem_done_in is sampled high.
- Completion:
  - Edge where mem_done_in=1: mem_ena_out=0, state -> IDLE.
  - For a load that is not discarded: cdb_valid_out=1 for exactly one cycle, with the latched tag and the extended result.
  - Minimum latency from ena_in to cdb_valid_out is 2 edges plus memory latency.
  - A new ena_in is accepted from the cycle after state returns to IDLE.
- Extension of mem_rdata_in:
  - LB: sign-extend [7:0]. LBU: zero-extend [7:0].
  - LH: sign-extend [15:0]. LHU: zero-extend [15:0].
  - LW: passthrough.
- Stores never assert cdb_valid_out, because they are already committed in the ROB.
- cdb_valid_out deasserts the following cycle; cdb_result_out and cdb_rob_id_out may hold stale values while valid=0.
- Flush (flush_in=1):
  - Load in REQ: set the discard flag. Stay in REQ until mem_done_in, because the controller cannot abort. Suppress the CDB broadcast. Clear discard on completion.
  - Store in REQ: unaffected, completes normally.
  - ena_in carrying a load in the same cycle as flush_in: dropped, state stays IDLE.
  - ena_in carrying a store in the same cycle as flush_in: accepted.
  - Flush in IDLE: no effect.
  - A cdb_valid_out already registered is not retracted.
- mem_done_in while IDLE: ignored.
- Reset while in REQ: return to IDLE with mem_ena_out=0 next cycle. The controller is reset by the same rst.
- Alignment: the unit does not check address alignment; the controller splits accesses bytewise.

Decomposition:
- Shared package (defines):
  - OPENUM codes, with loads ordered LB..LHU before stores SB..SW so that "<= LHU" identifies a load.
  - OPENUM_W, ROB_ID_W, DATA_W, ADDR_W.
  - ZERO_ROB, ZERO_WORD, TRUE/FALSE.
- Sub-module ls_load_extender: purely combinational; takes opcode and raw data, produces the extended result. It is reusable for store-to-load forwarding later.

Test Plan:
- LW: issue LW addr=0x1000 tag=3; mem_done after 3 cycles with rdata=0xDEADBEEF -> one cdb_valid pulse, tag 3, result 0xDEADBEEF; mem_size=4; busy high from the issue cycle through the completion edge.
- Load extension:
  - LB rdata=0x00000080 -> 0xFFFFFF80.
  - LBU same rdata -> 0x00000080.
  - LH rdata=0x0000F00F -> 0xFFFFF00F.
  - LHU same rdata -> 0x0000F00F.
- SH: issue SH addr=0x20 value=0x12345678 tag=5 -> mem_wr=1, size=2, wdata=0x12345678 held until done; no cdb_valid at any time.
- Flush: LW tag=7 outstanding, flush_in pulses, mem_done 2 cycles later with rdata=0x55 -> no cdb_valid, busy drops after done; a subsequent issue is accepted normally.
- Stall: rdy=0 for 4 cycles mid-REQ with mem_done_in toggling -> all outputs frozen; after rdy=1, the real done pulse completes the load exactly once.
- Back-to-back: ena_in while REQ is impossible by protocol; check busy_out=1 in every cycle between issue and done, and that a second issue the cycle after IDLE starts a new request with the new fields.
